// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, redirect flushes, data-memory waits.
// Optional decode-stage branch resolution is enabled with `define BRANCH_IN_DECODE_EN.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  RsAddr_D,
   input  logic [4:0]  RtAddr_D,
   input  logic [4:0]  RsAddr_E,
   input  logic [4:0]  RtAddr_E,
   input  logic [4:0]  RegDstAddr_E,
   input  logic [4:0]  RegDstAddr_M,
   input  logic        RegWriteEN_E,
   input  logic        RegWriteEN_M,
   input  logic        MemToReg_E,
   input  logic        MemToReg_M,
   input  logic        Branch_D,
   input  logic        BranchTaken_D,
   input  logic        BranchTaken_E,
   input  logic        Jump_D,
   input  logic        MemReq_M,
   input  logic        MemReady,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushW,
   output logic        MemError,
   output logic [15:0] StallCycles
);

   typedef enum logic [0:0] {StRun, StMemWait} state_e;

   state_e      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        mem_err_q, mem_err_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic memwait, loaduse, match_e, timeout;
   logic br_hazard, redirect_d, redirect_e;
   logic unused_inputs;

   assign memwait = MemReq_M & ~MemReady;
   assign match_e = (RegDstAddr_E == RsAddr_D) | (RegDstAddr_E == RtAddr_D);
   assign loaduse = MemToReg_E & RegWriteEN_E & (RegDstAddr_E != 5'd0) & match_e;
   // Timeout fires in the MEM_TIMEOUT-th MEM_WAIT cycle, the same cycle MemError is high.
   assign timeout = (state_q == StMemWait) && (wait_cnt_q == 8'(MEM_TIMEOUT - 1));

`ifdef BRANCH_IN_DECODE_EN
   logic match_m;
   assign match_m    = (RegDstAddr_M == RsAddr_D) | (RegDstAddr_M == RtAddr_D);
   assign br_hazard  = Branch_D & ((RegWriteEN_E & (RegDstAddr_E != 5'd0) & match_e) |
                                   (MemToReg_M & (RegDstAddr_M != 5'd0) & match_m));
   assign redirect_d = (Branch_D & BranchTaken_D) | Jump_D;
   assign redirect_e = 1'b0;
   assign unused_inputs = ^{RsAddr_E, RtAddr_E, RegWriteEN_M, BranchTaken_E};
`else
   assign br_hazard  = 1'b0;
   assign redirect_d = BranchTaken_E | Jump_D;
   assign redirect_e = BranchTaken_E;
   assign unused_inputs = ^{RsAddr_E, RtAddr_E, RegWriteEN_M, MemToReg_M, RegDstAddr_M,
                            Branch_D, BranchTaken_D};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         wait_cnt_q  <= 8'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         StRun: begin
            wait_cnt_d = 8'd0;
            if (memwait) state_d = StMemWait;
         end
         StMemWait: begin
            if (MemReady || timeout) begin
               state_d    = StRun;
               wait_cnt_d = 8'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: state_d = StRun;
      endcase
      mem_err_d   = (state_d == StMemWait) && (wait_cnt_d == 8'(MEM_TIMEOUT - 1));
      stall_cnt_d = stall_cnt_q;
      if (StallF && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (!rst) begin
         if (((state_q == StRun) && memwait) ||
             ((state_q == StMemWait) && !MemReady && !timeout)) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (loaduse || br_hazard) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end else if (redirect_d) begin
            FlushD = 1'b1;
            FlushE = redirect_e;
         end
      end
   end

   assign MemError    = mem_err_q;
   assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4).
// Expectations follow BRANCH_IN_DECODE_EN when it is defined for the build.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  RsAddr_D, RtAddr_D, RsAddr_E, RtAddr_E, RegDstAddr_E, RegDstAddr_M;
   logic        RegWriteEN_E, RegWriteEN_M, MemToReg_E, MemToReg_M;
   logic        Branch_D, BranchTaken_D, BranchTaken_E, Jump_D, MemReq_M, MemReady;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemError;
   logic [15:0] StallCycles;
   logic [6:0]  ctl, exp;
   int          n_checks = 0;
   int          n_fail = 0;

   // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
   localparam logic [6:0] Idle = 7'b0000000;
   localparam logic [6:0] Freeze = 7'b1111001;
   localparam logic [6:0] Bubble = 7'b1100010;
   localparam logic [6:0] FlD = 7'b0000100;
   localparam logic [6:0] FlDE = 7'b0000110;

   assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .RsAddr_D(RsAddr_D), .RtAddr_D(RtAddr_D), .RsAddr_E(RsAddr_E), .RtAddr_E(RtAddr_E),
      .RegDstAddr_E(RegDstAddr_E), .RegDstAddr_M(RegDstAddr_M),
      .RegWriteEN_E(RegWriteEN_E), .RegWriteEN_M(RegWriteEN_M),
      .MemToReg_E(MemToReg_E), .MemToReg_M(MemToReg_M),
      .Branch_D(Branch_D), .BranchTaken_D(BranchTaken_D), .BranchTaken_E(BranchTaken_E),
      .Jump_D(Jump_D), .MemReq_M(MemReq_M), .MemReady(MemReady),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .MemError(MemError), .StallCycles(StallCycles)
   );

   task automatic idle_inputs();
      RsAddr_D = 5'd0; RtAddr_D = 5'd0; RsAddr_E = 5'd0; RtAddr_E = 5'd0;
      RegDstAddr_E = 5'd0; RegDstAddr_M = 5'd0;
      RegWriteEN_E = 1'b0; RegWriteEN_M = 1'b0; MemToReg_E = 1'b0; MemToReg_M = 1'b0;
      Branch_D = 1'b0; BranchTaken_D = 1'b0; BranchTaken_E = 1'b0; Jump_D = 1'b0;
      MemReq_M = 1'b0; MemReady = 1'b0;
   endtask

   // Inputs change 1 ns after the rising edge; checks happen 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic lw_in_e(input logic [4:0] rd);
      MemToReg_E = 1'b1; RegWriteEN_E = 1'b1; RegDstAddr_E = rd;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      MemReq_M = 1'b1;
      lw_in_e(5'd3); RsAddr_D = 5'd3; Jump_D = 1'b1;
      #1;
      n_checks++;
      if (ctl !== Idle) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, Idle); end
      tick();
      tick();
      n_checks++;
      if (StallCycles !== 16'd0) begin
         n_fail++; $display("FAIL reset_stallcycles: got %0d want 0", StallCycles);
      end
      n_checks++;
      if (MemError !== 1'b0) begin n_fail++; $display("FAIL reset_memerror: got %b want 0", MemError); end
      rst = 1'b0;
      idle_inputs();
      #1;
      n_checks++;
      if (ctl !== Idle) begin n_fail++; $display("FAIL post_reset_ctl: got %b want %b", ctl, Idle); end
   endtask

   task automatic test_load_use();
      do_reset();
      lw_in_e(5'd2); RsAddr_D = 5'd2;
      #1;
      n_checks++;
      if (ctl !== Bubble) begin n_fail++; $display("FAIL loaduse_rs: got %b want %b", ctl, Bubble); end
      tick();
      // load moved to M, bubble in E
      idle_inputs(); RsAddr_D = 5'd2;
      MemToReg_M = 1'b1; RegWriteEN_M = 1'b1; RegDstAddr_M = 5'd2;
      #1;
      n_checks++;
      if (ctl !== Idle) begin n_fail++; $display("FAIL loaduse_release: got %b want %b", ctl, Idle); end
      n_checks++;
      if (StallCycles !== 16'd1) begin
         n_fail++; $display("FAIL loaduse_count: got %0d want 1", StallCycles);
      end
      tick();
      idle_inputs(); lw_in_e(5'd9); RtAddr_D = 5'd9; RsAddr_D = 5'd4;
      #1;
      n_checks++;
      if (ctl !== Bubble) begin n_fail++; $display("FAIL loaduse_rt: got %b want %b", ctl, Bubble); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      lw_in_e(5'd0); RsAddr_D = 5'd0; RtAddr_D = 5'd0;
      #1;
      n_checks++;
      if (ctl !== Idle) begin n_fail++; $display("FAIL zero_reg: got %b want %b", ctl, Idle); end
      tick();
      lw_in_e(5'd3); RegWriteEN_E = 1'b0; RsAddr_D = 5'd3;
      #1;
      n_checks++;
      if (ctl !== Idle) begin n_fail++; $display("FAIL no_write_load: got %b want %b", ctl, Idle); end
   endtask

   task automatic test_mem_wait();
      do_reset();
      MemReq_M = 1'b1; MemReady = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (ctl !== Freeze) begin
            n_fail++; $display("FAIL memwait_c%0d: got %b want %b", c, ctl, Freeze);
         end
         tick();
      end
      // release cycle still applies the load-use rule
      MemReady = 1'b1; lw_in_e(5'd7); RsAddr_D = 5'd7;
      #1;
      n_checks++;
      if (ctl !== Bubble) begin n_fail++; $display("FAIL memwait_release: got %b want %b", ctl, Bubble); end
      n_checks++;
      if (StallCycles !== 16'd3) begin
         n_fail++; $display("FAIL memwait_count: got %0d want 3", StallCycles);
      end
      tick();
      idle_inputs();
      #1;
      n_checks++;
      if (ctl !== Idle) begin n_fail++; $display("FAIL memwait_run: got %b want %b", ctl, Idle); end
      n_checks++;
      if (StallCycles !== 16'd4) begin
         n_fail++; $display("FAIL memwait_count2: got %0d want 4", StallCycles);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      MemReq_M = 1'b1; MemReady = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++;
         if ({ctl, MemError} !== {Freeze, 1'b0}) begin
            n_fail++; $display("FAIL timeout_wait_c%0d: got %b/%b want %b/0", c, ctl, MemError, Freeze);
         end
         tick();
      end
      #1;
      n_checks++;
      if ({ctl, MemError} !== {Idle, 1'b1}) begin
         n_fail++; $display("FAIL timeout_fire: got %b/%b want %b/1", ctl, MemError, Idle);
      end
      tick();
      MemReq_M = 1'b0;
      #1;
      n_checks++;
      if (MemError !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b want 0", MemError); end
      n_checks++;
      if (StallCycles !== 16'd4) begin
         n_fail++; $display("FAIL timeout_count: got %0d want 4", StallCycles);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      MemReq_M = 1'b1; MemReady = 1'b0; lw_in_e(5'd6); RtAddr_D = 5'd6;
      #1;
      n_checks++;
      if (ctl !== Freeze) begin n_fail++; $display("FAIL simul_run: got %b want %b", ctl, Freeze); end
      tick();
      #1;
      n_checks++;
      if (ctl !== Freeze) begin n_fail++; $display("FAIL simul_wait: got %b want %b", ctl, Freeze); end
      tick();
      MemReady = 1'b1;
      #1;
      n_checks++;
      if (ctl !== Bubble) begin n_fail++; $display("FAIL simul_release: got %b want %b", ctl, Bubble); end
   endtask

   task automatic test_redirect();
      do_reset();
      Jump_D = 1'b1;
      #1;
      n_checks++;
      if (ctl !== FlD) begin n_fail++; $display("FAIL redirect_jump: got %b want %b", ctl, FlD); end
      tick();
      idle_inputs(); BranchTaken_E = 1'b1;
      #1;
`ifdef BRANCH_IN_DECODE_EN
      exp = Idle;
`else
      exp = FlDE;
`endif
      n_checks++;
      if (ctl !== exp) begin n_fail++; $display("FAIL redirect_taken_e: got %b want %b", ctl, exp); end
      tick();
      idle_inputs(); Branch_D = 1'b1; BranchTaken_D = 1'b1;
      #1;
`ifdef BRANCH_IN_DECODE_EN
      exp = FlD;
`else
      exp = Idle;
`endif
      n_checks++;
      if (ctl !== exp) begin n_fail++; $display("FAIL redirect_taken_d: got %b want %b", ctl, exp); end
   endtask

   task automatic test_branch();
      do_reset();
      Branch_D = 1'b1; RsAddr_D = 5'd5; lw_in_e(5'd5);
      #1;
      n_checks++;
      if (ctl !== Bubble) begin n_fail++; $display("FAIL branch_c1: got %b want %b", ctl, Bubble); end
      tick();
      idle_inputs(); Branch_D = 1'b1; RsAddr_D = 5'd5;
      MemToReg_M = 1'b1; RegWriteEN_M = 1'b1; RegDstAddr_M = 5'd5;
      #1;
`ifdef BRANCH_IN_DECODE_EN
      exp = Bubble;
`else
      exp = Idle;
`endif
      n_checks++;
      if (ctl !== exp) begin n_fail++; $display("FAIL branch_c2: got %b want %b", ctl, exp); end
      tick();
      idle_inputs(); Branch_D = 1'b1; BranchTaken_D = 1'b1; RsAddr_D = 5'd5;
      #1;
`ifdef BRANCH_IN_DECODE_EN
      exp = FlD;
`else
      exp = Idle;
`endif
      n_checks++;
      if (ctl !== exp) begin n_fail++; $display("FAIL branch_c3: got %b want %b", ctl, exp); end
      tick();
      idle_inputs(); Branch_D = 1'b1; RtAddr_D = 5'd8; RegWriteEN_E = 1'b1; RegDstAddr_E = 5'd8;
      #1;
`ifdef BRANCH_IN_DECODE_EN
      exp = Bubble;
`else
      exp = Idle;
`endif
      n_checks++;
      if (ctl !== exp) begin n_fail++; $display("FAIL branch_alu: got %b want %b", ctl, exp); end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      MemReq_M = 1'b1; MemReady = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (ctl !== Idle) begin n_fail++; $display("FAIL rstwait_ctl: got %b want %b", ctl, Idle); end
      tick();
      rst = 1'b0; MemReq_M = 1'b0;
      #1;
      n_checks++;
      if ({MemError, StallCycles} !== {1'b0, 16'd0}) begin
         n_fail++; $display("FAIL rstwait_state: got err=%b cnt=%0d want 0/0", MemError, StallCycles);
      end
      n_checks++;
      if (ctl !== Idle) begin n_fail++; $display("FAIL rstwait_run: got %b want %b", ctl, Idle); end
      tick();
      #1;
      n_checks++;
      if (MemError !== 1'b0) begin n_fail++; $display("FAIL rstwait_noerr: got %b want 0", MemError); end
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      exp = Idle;
      test_reset();
      test_load_use();
      test_zero_reg();
      test_mem_wait();
      test_timeout();
      test_simultaneous();
      test_redirect();
      test_branch();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It generates per-stage stall and flush controls for load-use hazards, decode-stage branch operand hazards, taken branches/jumps, and multi-cycle data-memory waits. It sits beside the forwarding units: forwarding resolves ALU-result dependencies, and `hazard_ctrl` freezes or bubbles the pipeline registers where forwarding cannot. It also keeps a memory-wait timeout watchdog and a saturating stall-cycle counter.

## Interface
- Clock and reset: one clock; reset is synchronous and active-high.
- `MEM_TIMEOUT`, default 255: maximum consecutive MEM_WAIT cycles before `MemError`. Must be 1..255; the wait counter is 8 bits.
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `RsAddr_D`, `RtAddr_D` input 5: source registers of the instruction in D.
- `RsAddr_E`, `RtAddr_E` input 5: source registers of the instruction in E.
- `RegDstAddr_E`, `RegDstAddr_M` input 5: destination registers in E and M.
- `RegWriteEN_E`, `RegWriteEN_M` input 1: register write enables in E and M.
- `MemToReg_E`, `MemToReg_M` input 1: instruction in E or M is a load.
- `Branch_D` input 1: the instruction in D is a conditional branch.
- `BranchTaken_D` input 1: decode-stage branch comparison result.
- `BranchTaken_E` input 1: execute-stage branch comparison result.
- `Jump_D` input 1: the instruction in D is j, jal or jr.
- `MemReq_M` input 1: the instruction in M accesses data memory.
- `MemReady` input 1: data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM` output 1: hold the PC or the named pipeline register.
- `FlushD`, `FlushE`, `FlushW` output 1: load a bubble into the D, E or W pipeline register.
- `MemError` output 1: one-cycle pulse when the memory-wait timeout fires.
- `StallCycles` output 16: saturating count of cycles with `StallF` = 1.

## Operation
- FSM states:
  - RUN: reset state.
  - MEM_WAIT.
- Condition definitions:
  - `memwait` = `MemReq_M` & !`MemReady`.
  - `loaduse` = `MemToReg_E` & `RegWriteEN_E` & (`RegDstAddr_E` != 0) & (`RegDstAddr_E` == `RsAddr_D` or `RegDstAddr_E` == `RtAddr_D`).
- RUN, first matching rule wins:
  1. `memwait`: `StallF`, `StallD`, `StallE` and `StallM` = 1; `FlushW` = 1. Next state MEM_WAIT.
  2. `loaduse` or branch hazard (see Configuration): `StallF` = `StallD` = 1; `FlushE` = 1.
  3. Taken redirect (see Configuration): `FlushD` = 1, plus `FlushE` when resolving in E.
  4. Otherwise all stall and flush outputs are 0.
- MEM_WAIT:
  - Outputs are the same as RUN rule 1 while `MemReady` = 0. Lower-priority hazards are masked, because the whole front end is frozen.
  - `MemReady` = 1: all stalls drop that same cycle, and the rule 2/3 evaluation is applied. Next state RUN.
  - The wait counter increments each MEM_WAIT cycle.
  - When the counter reaches `MEM_TIMEOUT`: `MemError` = 1 for that cycle, the next state is RUN, and the counter clears. M is released, and the access is treated as complete with undefined data.
  - The wait counter clears on every entry to RUN.
- `RsAddr_E`/`RtAddr_E` are unused in hazard logic; they are present for future multiply-unit hazards and ignored today.
- `StallCycles` increments on each cycle with `StallF` = 1 and holds at 0xFFFF.

## Timing
- All stall and flush outputs are combinational from the current state and inputs, and valid in the same cycle. Pipeline registers sample them at the next rising edge.
- The state, wait counter, `StallCycles` and the registered `MemError` update on the rising edge.
- The load-use stall lasts exactly 1 cycle: the load advances to M, and forwarding covers the rest.
- The branch hazard lasts 1 cycle for an ALU producer in E, and 2 cycles for a load producer (E, then M).
- Reset:
  - `rst` = 1 at an edge forces RUN, wait counter = 0, `StallCycles` = 0, `MemError` = 0.
  - While `rst` is high, all stall and flush outputs are 0.
  - Reset mid-MEM_WAIT aborts the wait with no `MemError`.
- Simultaneous `memwait` and `loaduse`: memwait wins; `FlushE` = 0, so E is held, not bubbled.

## Configuration
- Macro: `BRANCH_IN_DECODE_EN`.
- Defined (branches resolve in D):
  - Branch hazard = `Branch_D` & ((`RegWriteEN_E` & `RegDstAddr_E` != 0 & `RegDstAddr_E` matches Rs_D/Rt_D) or (`MemToReg_M` & `RegDstAddr_M` != 0 & `RegDstAddr_M` matches Rs_D/Rt_D)).
  - Taken redirect = (`Branch_D` & `BranchTaken_D` & no hazard) or `Jump_D`; it flushes D only.
  - `BranchTaken_E` is ignored.
- Undefined (branches resolve in E):
  - No branch hazard term.
  - Taken redirect = `BranchTaken_E`, which flushes D and E.
  - `Jump_D` flushes D.
  - `Branch_D` and `BranchTaken_D` are ignored.

## Test plan
- Load-use: lw $2 in E (`RegDstAddr_E` = 2, `MemToReg_E` = 1) and `RsAddr_D` = 2 → for exactly 1 cycle `StallF` = `StallD` = `FlushE` = 1; `StallCycles` = 1.
- Zero-register load: same as the load-use case with `RegDstAddr_E` = 0 → no stall or flush.
- Memory wait: `MemReq_M` = 1, `MemReady` low for 3 cycles then high → `StallF`, `StallD`, `StallE`, `StallM` and `FlushW` = 1 for 3 cycles; state returns to RUN; `StallCycles` = 3.
- Timeout: `MEM_TIMEOUT` = 4, `MemReady` held 0 → a `MemError` pulse on the 4th MEM_WAIT cycle, then RUN.
- With `BRANCH_IN_DECODE_EN`, branch hazard: beq in D reading $5 while lw $5 is in E → 2 stall cycles, then `FlushD` = 1 when taken.
- Reset during MEM_WAIT: `rst` = 1 → the next cycle is RUN, `StallCycles` = 0, no `MemError`.
